// File: rtl/noc_slot_pkg.sv
// Shared types and default sizing for the packet-slot allocation path.
package noc_slot_pkg;

   localparam int unsigned DEF_NUM_ENTRIES = 8;
   localparam int unsigned DEF_NUM_REQ     = 4;
   localparam int unsigned DEF_QUOTA       = 4;
   localparam int unsigned SLOT_IDX_W      = $clog2(DEF_NUM_ENTRIES);
   localparam int unsigned REQ_ID_W        = $clog2(DEF_NUM_REQ);

   typedef logic [SLOT_IDX_W-1:0] slot_idx_t;
   typedef logic [REQ_ID_W-1:0]   req_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at/after the pointer, pointer moves past winner.
module rr_arbiter #(
   parameter int unsigned  N = 4,
   localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [N-1:0] i_req,
   input  logic         i_advance,
   output logic [N-1:0] o_gnt,
   output logic [W-1:0] o_gnt_id
);

   logic [W-1:0] r_ptr;
   logic [W-1:0] w_pos;
   logic         w_found;

   always_comb begin
      o_gnt    = '0;
      o_gnt_id = '0;
      w_pos    = '0;
      w_found  = 1'b0;
      for (int k = 0; k < int'(N); k++) begin
         w_pos = W'((int'(r_ptr) + k) % int'(N));
         if (!w_found && i_req[w_pos]) begin
            w_found  = 1'b1;
            o_gnt_id = w_pos;
         end
      end
      if (w_found) o_gnt[o_gnt_id] = 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ptr <= '0;
      end else if (i_advance && w_found) begin
         r_ptr <= (o_gnt_id == W'(N - 1)) ? '0 : o_gnt_id + 1'b1;
      end
   end

endmodule

// File: rtl/slot_alloc_arbiter.sv
// Shares the free slot pool among requesters with per-requester quotas and
// ownership tracking so that illegal or double frees never reach the pool.
module slot_alloc_arbiter
   import noc_slot_pkg::*;
#(
   parameter int unsigned  NUM_ENTRIES = DEF_NUM_ENTRIES,
   parameter int unsigned  NUM_REQ     = DEF_NUM_REQ,
   parameter int unsigned  QUOTA       = DEF_QUOTA,
   localparam int unsigned IDX_W       = $clog2(NUM_ENTRIES),
   localparam int unsigned ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     nocclk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       alloc_req,
   output logic [NUM_REQ-1:0]       alloc_gnt,
   output logic [IDX_W-1:0]         alloc_index,
   input  logic                     free_valid,
   input  logic [IDX_W-1:0]         free_index,
   output logic                     free_ready,
   input  logic [NUM_REQ-1:0]       ret_valid,
   input  logic [NUM_REQ*IDX_W-1:0] ret_index,
   output logic [NUM_REQ-1:0]       ret_ready,
   output logic                     return_index_valid,
   output logic [IDX_W-1:0]         return_index,
   output logic [IDX_W:0]           outstanding_total,
   output logic                     err_illegal_ret,
   output logic [ID_W-1:0]          err_req_id
);

   localparam int unsigned CNT_W = $clog2(QUOTA + 1);
   localparam int unsigned TOT_W = IDX_W + 1;

   logic [CNT_W-1:0]       r_cnt [NUM_REQ];
   logic [NUM_ENTRIES-1:0] r_owned;
   logic [ID_W-1:0]        r_owner [NUM_ENTRIES];
   logic                   r_ret_valid;
   logic [IDX_W-1:0]       r_ret_idx;
   logic                   r_err;
   logic [ID_W-1:0]        r_err_id;

   logic [NUM_REQ-1:0]     w_elig;
   logic [ID_W-1:0]        w_agnt_id;
   logic [ID_W-1:0]        w_ret_id;
   logic [IDX_W-1:0]       w_ret_idx;
   logic                   w_ret_any;
   logic                   w_ret_legal;
   logic [TOT_W-1:0]       w_total;

   always_comb begin
      w_elig = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         w_elig[i] = alloc_req[i] && (r_cnt[i] < CNT_W'(QUOTA));
      end
   end

   rr_arbiter #(.N(NUM_REQ)) u_alloc_arb (
      .i_clk     (nocclk),
      .i_rst     (rst),
      .i_req     (w_elig & {NUM_REQ{free_valid}}),
      .i_advance (1'b1),
      .o_gnt     (alloc_gnt),
      .o_gnt_id  (w_agnt_id)
   );

   rr_arbiter #(.N(NUM_REQ)) u_ret_arb (
      .i_clk     (nocclk),
      .i_rst     (rst),
      .i_req     (ret_valid),
      .i_advance (1'b1),
      .o_gnt     (ret_ready),
      .o_gnt_id  (w_ret_id)
   );

   assign alloc_index = free_index;
   assign free_ready  = |alloc_gnt;
   assign w_ret_any   = |ret_ready;

   // Legality uses registered ownership, so a same-cycle grant cannot be returned.
   always_comb begin
      w_ret_idx = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (ret_ready[i]) w_ret_idx = ret_index[i*IDX_W +: IDX_W];
      end
      w_ret_legal = w_ret_any && r_owned[w_ret_idx] && (r_owner[w_ret_idx] == w_ret_id);
   end

   always_comb begin
      w_total = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         w_total = w_total + TOT_W'(r_cnt[i]);
      end
   end

   always_ff @(posedge nocclk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_REQ); i++) r_cnt[i] <= '0;
         for (int e = 0; e < int'(NUM_ENTRIES); e++) r_owner[e] <= '0;
         r_owned     <= '0;
         r_ret_valid <= 1'b0;
         r_ret_idx   <= '0;
         r_err       <= 1'b0;
         r_err_id    <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (alloc_gnt[i] && !(w_ret_legal && ret_ready[i])) begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end else if (!alloc_gnt[i] && w_ret_legal && ret_ready[i]) begin
               r_cnt[i] <= r_cnt[i] - 1'b1;
            end
         end
         if (|alloc_gnt) begin
            r_owned[free_index] <= 1'b1;
            r_owner[free_index] <= w_agnt_id;
         end
         if (w_ret_legal) begin
            r_owned[w_ret_idx] <= 1'b0;
            r_ret_idx          <= w_ret_idx;
         end
         r_ret_valid <= w_ret_legal;
         if (w_ret_any && !w_ret_legal && !r_err) begin
            r_err    <= 1'b1;
            r_err_id <= w_ret_id;
         end
      end
   end

   assign return_index_valid = r_ret_valid;
   assign return_index       = r_ret_idx;
   assign outstanding_total  = w_total;
   assign err_illegal_ret    = r_err;
   assign err_req_id         = r_err_id;

   a_alloc_onehot: assert property (@(posedge nocclk) disable iff (rst) $onehot0(alloc_gnt));
   a_ret_onehot:   assert property (@(posedge nocclk) disable iff (rst) $onehot0(ret_ready));

   for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_quota_chk
      a_quota: assert property (@(posedge nocclk) disable iff (rst) r_cnt[g] <= CNT_W'(QUOTA));
   end

endmodule

// File: tb/tb_slot_alloc_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/accepts/pushes, a negedge monitor checks them.
module tb_slot_alloc_arbiter;
   import noc_slot_pkg::*;

   localparam int unsigned NR  = 4;
   localparam int unsigned IW  = SLOT_IDX_W;
   localparam int unsigned IDW = REQ_ID_W;

   logic             nocclk = 1'b0;
   logic             rst    = 1'b1;
   logic [NR-1:0]    alloc_req, alloc_gnt, ret_valid, ret_ready;
   slot_idx_t        alloc_index, free_index, return_index;
   logic             free_valid, free_ready, return_index_valid, err_illegal_ret;
   logic [NR*IW-1:0] ret_index;
   logic [IW:0]      outstanding_total;
   req_id_t          err_req_id;

   int n_checks = 0;
   int n_errors = 0;

   logic [NR+IW-1:0] q_gnt [$];
   logic [NR-1:0]    q_ret [$];
   slot_idx_t        q_push [$];

   slot_alloc_arbiter #(.NUM_ENTRIES(8), .NUM_REQ(NR), .QUOTA(2)) dut (
      .nocclk             (nocclk),
      .rst                (rst),
      .alloc_req          (alloc_req),
      .alloc_gnt          (alloc_gnt),
      .alloc_index        (alloc_index),
      .free_valid         (free_valid),
      .free_index         (free_index),
      .free_ready         (free_ready),
      .ret_valid          (ret_valid),
      .ret_index          (ret_index),
      .ret_ready          (ret_ready),
      .return_index_valid (return_index_valid),
      .return_index       (return_index),
      .outstanding_total  (outstanding_total),
      .err_illegal_ret    (err_illegal_ret),
      .err_req_id         (err_req_id)
   );

   always #5 nocclk = ~nocclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got 0x%0h expected nothing", name, act);
   endtask

   task automatic step();
      @(posedge nocclk);
      #1;
   endtask

   task automatic set_ret(input int r, input int idx);
      ret_index[r*IW +: IW] = IW'(idx);
   endtask

   // Monitor
   initial begin
      forever begin
         @(negedge nocclk);
         if (|alloc_gnt) begin
            if (q_gnt.size() == 0) unexpected("grant", {alloc_gnt, alloc_index});
            else begin
               check("grant", {alloc_gnt, alloc_index}, q_gnt.pop_front());
               check("free_ready", free_ready, 1);
            end
         end
         if (|ret_ready) begin
            if (q_ret.size() == 0) unexpected("ret_ready", ret_ready);
            else check("ret_ready", ret_ready, q_ret.pop_front());
         end
         if (return_index_valid) begin
            if (q_push.size() == 0) unexpected("push", return_index);
            else check("push", return_index, q_push.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      alloc_req  = '0;
      free_valid = 1'b0;
      free_index = '0;
      ret_valid  = '0;
      ret_index  = '0;
      rst        = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("rst_total", outstanding_total, 0);
      check("rst_push_valid", return_index_valid, 0);
      check("rst_push_idx", return_index, 0);
      check("rst_err", err_illegal_ret, 0);
      check("rst_err_id", err_req_id, 0);

      // Quota of 2 for a lone requester
      alloc_req  = 4'b0001;
      free_valid = 1'b1;
      free_index = 3'd0; q_gnt.push_back({4'b0001, 3'd0}); step();
      free_index = 3'd1; q_gnt.push_back({4'b0001, 3'd1}); step();
      free_index = 3'd2;
      #1;
      check("quota_gnt", alloc_gnt, 0);
      check("quota_free_ready", free_ready, 0);
      step();
      step();
      check("quota_total", outstanding_total, 2);
      alloc_req = '0;
      ret_valid = 4'b0001; set_ret(0, 0);
      q_ret.push_back(4'b0001); q_push.push_back(3'd0);
      step();
      ret_valid = '0;
      check("after_ret_total", outstanding_total, 1);
      alloc_req = 4'b0001; q_gnt.push_back({4'b0001, 3'd2}); step();
      alloc_req = '0;
      check("regrant_total", outstanding_total, 2);

      // Reset mid-stream with a legal return in flight
      alloc_req  = 4'b1111;
      free_index = 3'd3; q_gnt.push_back({4'b0010, 3'd3}); step();
      free_index = 3'd4; q_gnt.push_back({4'b0100, 3'd4});
      ret_valid = 4'b0001; set_ret(0, 2); q_ret.push_back(4'b0001);
      step();
      alloc_req = '0;
      ret_valid = '0;
      rst = 1'b1;
      #1;
      check("midrst_push_valid", return_index_valid, 0);
      check("midrst_total", outstanding_total, 0);
      step();
      rst = 1'b0;

      // Round-robin from requester 0 after reset
      alloc_req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         free_index = IW'(k);
         q_gnt.push_back({4'(1 << k), 3'(k)});
         step();
      end
      alloc_req = '0;
      check("rr_total", outstanding_total, 4);

      // Legal return by owner
      alloc_req = 4'b0010; free_index = 3'd5; q_gnt.push_back({4'b0010, 3'd5}); step();
      alloc_req = '0;
      check("own5_total", outstanding_total, 5);
      ret_valid = 4'b0010; set_ret(1, 5);
      q_ret.push_back(4'b0010); q_push.push_back(3'd5);
      step();
      ret_valid = '0;
      check("ret5_total", outstanding_total, 4);

      // Illegal returns: freed index, then foreign index
      ret_valid = 4'b0100; set_ret(2, 5); q_ret.push_back(4'b0100); step();
      ret_valid = '0;
      check("ill_err", err_illegal_ret, 1);
      check("ill_err_id", err_req_id, 2);
      check("ill_total", outstanding_total, 4);
      ret_valid = 4'b1000; set_ret(3, 1); q_ret.push_back(4'b1000); step();
      ret_valid = '0;
      check("ill2_err", err_illegal_ret, 1);
      check("ill2_err_id_kept", err_req_id, 2);
      check("ill2_total", outstanding_total, 4);

      // Three simultaneous returns accepted in order 0,1,3
      set_ret(0, 0); set_ret(1, 1); set_ret(3, 3);
      ret_valid = 4'b1011; q_ret.push_back(4'b0001); q_push.push_back(3'd0); step();
      check("multi_push1", return_index_valid, 1);
      ret_valid = 4'b1010; q_ret.push_back(4'b0010); q_push.push_back(3'd1); step();
      check("multi_push2", return_index_valid, 1);
      ret_valid = 4'b1000; q_ret.push_back(4'b1000); q_push.push_back(3'd3); step();
      check("multi_push3", return_index_valid, 1);
      ret_valid = '0;
      check("multi_total", outstanding_total, 1);

      // Grant and legal return by the same requester in one cycle
      alloc_req = 4'b0100; free_index = 3'd6; q_gnt.push_back({4'b0100, 3'd6});
      ret_valid = 4'b0100; set_ret(2, 2); q_ret.push_back(4'b0100); q_push.push_back(3'd2);
      step();
      alloc_req = '0;
      ret_valid = '0;
      free_valid = 1'b0;
      check("simul_total", outstanding_total, 1);

      repeat (3) step();
      check("q_gnt_empty", q_gnt.size(), 0);
      check("q_ret_empty", q_ret.size(), 0);
      check("q_push_empty", q_push.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
